// File: rtl/reg_arb_pkg.sv
// Shared constants for the register-file arbiter: FSM encoding, arbitration
// modes and default geometry.
package reg_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   localparam int DEF_NCH   = 6;
   localparam int DEF_AW    = 7;
   localparam int DEF_DW    = 16;
   localparam int DEF_DEPTH = 128;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr when mode is set,
// otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
   parameter int NCH = 6,
   parameter int PW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [PW-1:0]  ptr,
   input  logic           mode,
   output logic [NCH-1:0] grant
);

   localparam logic [PW:0] NCH_W = (PW+1)'(NCH);

   logic [PW:0] w_idx;
   logic        w_found;

   // Walk the channels starting at the search origin, wrapping past NCH-1.
   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int off = 0; off < NCH; off++) begin
         w_idx = (mode ? {1'b0, ptr} : '0) + (PW+1)'(off);
         if (w_idx >= NCH_W) begin
            w_idx = w_idx - NCH_W;
         end
         if (!w_found && req[w_idx[PW-1:0]]) begin
            grant[w_idx[PW-1:0]] = 1'b1;
            w_found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_arb_ctrl.sv
// Multi-channel register file: one arbitrated transaction at a time, with
// a two-edge request-to-ack handshake held until the requester lets go.
module reg_arb_ctrl
   import reg_arb_pkg::*;
#(
   parameter int NCH   = DEF_NCH,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_DEPTH,
   parameter int MODE  = MODE_RR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH-1:0]    ch_we,
   input  logic [NCH*AW-1:0] ch_addr,
   input  logic [NCH*DW-1:0] ch_din,
   output logic [NCH-1:0]    ch_ack,
   output logic [NCH-1:0]    ch_err,
   output logic [DW-1:0]     rd_data,
   output logic              wr_pulse,
   output logic [AW-1:0]     wr_addr,
   output logic [DW-1:0]     wr_data
);

   localparam int            PW      = $clog2(NCH);
   localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [PW-1:0] LAST_CH = PW'(NCH-1);

   logic [1:0]     r_state;
   logic [PW-1:0]  r_ptr;
   logic [PW-1:0]  r_gidx;
   logic           r_we;
   logic [AW-1:0]  r_addr;
   logic [DW-1:0]  r_din;
   logic [NCH-1:0] r_ack;
   logic [NCH-1:0] r_err;
   logic [DW-1:0]  r_rdData;
   logic           r_wrPulse;
   logic [AW-1:0]  r_wrAddr;
   logic [DW-1:0]  r_wrData;
   logic [DW-1:0]  r_mem [DEPTH];

   logic [NCH-1:0] w_grant;
   logic [PW-1:0]  w_gidx;
   logic           w_we;
   logic [AW-1:0]  w_addr;
   logic [DW-1:0]  w_din;
   logic           w_inRange;

   rr_arbiter #(
      .NCH (NCH),
      .PW  (PW)
   ) u_arb (
      .req   (ch_req),
      .ptr   (r_ptr),
      .mode  (MODE == MODE_RR),
      .grant (w_grant)
   );

   always_comb begin
      w_gidx = '0;
      w_we   = 1'b0;
      w_addr = '0;
      w_din  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant[i]) begin
            w_gidx = PW'(i);
            w_we   = ch_we[i];
            w_addr = ch_addr[i*AW +: AW];
            w_din  = ch_din[i*DW +: DW];
         end
      end
   end

   assign w_inRange = ({1'b0, r_addr} < DEPTH_W);

   // Registers are cleared by reset, so a reset coinciding with a commit drops the write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == ST_ACCESS && r_we && w_inRange) begin
         r_mem[r_addr[IW-1:0]] <= r_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_gidx    <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_din     <= '0;
         r_ack     <= '0;
         r_err     <= '0;
         r_rdData  <= '0;
         r_wrPulse <= 1'b0;
         r_wrAddr  <= '0;
         r_wrData  <= '0;
      end else begin
         r_wrPulse <= 1'b0;
         r_wrAddr  <= '0;
         r_wrData  <= '0;
         case (r_state)
            ST_IDLE: begin
               if (|ch_req) begin
                  r_gidx  <= w_gidx;
                  r_we    <= w_we;
                  r_addr  <= w_addr;
                  r_din   <= w_din;
                  r_state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               r_ack <= NCH'(1) << r_gidx;
               if (w_inRange) begin
                  if (r_we) begin
                     r_wrPulse <= 1'b1;
                     r_wrAddr  <= r_addr;
                     r_wrData  <= r_din;
                  end else begin
                     r_rdData <= r_mem[r_addr[IW-1:0]];
                  end
               end else begin
                  r_err    <= NCH'(1) << r_gidx;
                  r_rdData <= '0;
               end
               r_state <= ST_ACK;
            end
            ST_ACK: begin
               // Round-robin resumes just past the channel that was served.
               if (!ch_req[r_gidx]) begin
                  r_ack    <= '0;
                  r_err    <= '0;
                  r_rdData <= '0;
                  r_ptr    <= (r_gidx == LAST_CH) ? '0 : r_gidx + PW'(1);
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ch_ack   = r_ack;
   assign ch_err   = r_err;
   assign rd_data  = r_rdData;
   assign wr_pulse = r_wrPulse;
   assign wr_addr  = r_wrAddr;
   assign wr_data  = r_wrData;

endmodule

// File: tb/tb_reg_arb_ctrl.sv
// Directed bench for reg_arb_ctrl: round-robin, fixed-priority and reduced-depth
// instances share one stimulus set; sel picks which one is being checked.
module tb_reg_arb_ctrl;
   import reg_arb_pkg::*;

   localparam int NCH = 6;
   localparam int AW  = 7;
   localparam int DW  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NCH-1:0]    chReq;
   logic [NCH-1:0]    chWe;
   logic [NCH*AW-1:0] chAddr;
   logic [NCH*DW-1:0] chDin;

   logic [NCH-1:0] ackA, errA, ackB, errB, ackC, errC;
   logic [DW-1:0]  rdA, rdB, rdC, wdA, wdB, wdC;
   logic [AW-1:0]  waA, waB, waC;
   logic           wpA, wpB, wpC;

   logic [NCH-1:0] sAck, sErr;
   logic [DW-1:0]  sRd, sWd;
   logic [AW-1:0]  sWa;
   logic           sWp;

   int sel;
   int nAsserts;
   int nFails;

   always #5 clk = ~clk;

   reg_arb_ctrl #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(128), .MODE(MODE_RR)) dutRr (
      .clk(clk), .rst(rst), .ch_req(chReq), .ch_we(chWe), .ch_addr(chAddr), .ch_din(chDin),
      .ch_ack(ackA), .ch_err(errA), .rd_data(rdA), .wr_pulse(wpA), .wr_addr(waA), .wr_data(wdA));

   reg_arb_ctrl #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(128), .MODE(MODE_FIXED)) dutFixed (
      .clk(clk), .rst(rst), .ch_req(chReq), .ch_we(chWe), .ch_addr(chAddr), .ch_din(chDin),
      .ch_ack(ackB), .ch_err(errB), .rd_data(rdB), .wr_pulse(wpB), .wr_addr(waB), .wr_data(wdB));

   reg_arb_ctrl #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(100), .MODE(MODE_RR)) dutSmall (
      .clk(clk), .rst(rst), .ch_req(chReq), .ch_we(chWe), .ch_addr(chAddr), .ch_din(chDin),
      .ch_ack(ackC), .ch_err(errC), .rd_data(rdC), .wr_pulse(wpC), .wr_addr(waC), .wr_data(wdC));

   assign sAck = (sel == 0) ? ackA : (sel == 1) ? ackB : ackC;
   assign sErr = (sel == 0) ? errA : (sel == 1) ? errB : errC;
   assign sRd  = (sel == 0) ? rdA  : (sel == 1) ? rdB  : rdC;
   assign sWd  = (sel == 0) ? wdA  : (sel == 1) ? wdB  : wdC;
   assign sWa  = (sel == 0) ? waA  : (sel == 1) ? waB  : waC;
   assign sWp  = (sel == 0) ? wpA  : (sel == 1) ? wpB  : wpC;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nAsserts++;
      if (observed !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic applyReset();
      chReq = '0;
      rst   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One complete transaction from IDLE; the granted channel's inputs are scrambled after capture.
   task automatic applyStimulus(input string tag, input int ch, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] din, input logic expErr, input logic [DW-1:0] expRd);
      logic expPulse;
      expPulse = we && !expErr;
      chWe[ch]             = we;
      chAddr[ch*AW +: AW]  = addr;
      chDin[ch*DW +: DW]   = din;
      chReq[ch]            = 1'b1;
      @(posedge clk); #1;
      checkOutput({tag, ":ackEarly"}, 32'(sAck), 32'h0);
      chAddr[ch*AW +: AW] = addr ^ 7'h01;
      chDin[ch*DW +: DW]  = ~din;
      chWe[ch]            = ~we;
      @(posedge clk); #1;
      checkOutput({tag, ":ack"}, 32'(sAck), 32'(1) << ch);
      checkOutput({tag, ":err"}, 32'(sErr), expErr ? (32'(1) << ch) : 32'h0);
      checkOutput({tag, ":wrPulse"}, 32'(sWp), 32'(expPulse));
      if (expPulse) begin
         checkOutput({tag, ":wrAddr"}, 32'(sWa), 32'(addr));
         checkOutput({tag, ":wrData"}, 32'(sWd), 32'(din));
      end
      if (!we) begin
         checkOutput({tag, ":rdData"}, 32'(sRd), 32'(expRd));
      end
      chReq[ch] = 1'b0;
      @(posedge clk); #1;
      checkOutput({tag, ":ackDrop"}, 32'(sAck), 32'h0);
      checkOutput({tag, ":rdDrop"}, 32'(sRd), 32'h0);
      checkOutput({tag, ":pulseEnd"}, 32'(sWp), 32'h0);
   endtask

   // Waits (bounded) for the next grant, expects channel ch after two edges, then releases it.
   task automatic serveNext(input string tag, input int ch, input logic reraise);
      int lat;
      bit seen;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 8) begin
         @(posedge clk); #1;
         lat++;
         checkOutput({tag, ":onehot"}, 32'($onehot0(sAck)), 32'h1);
         if (sAck != '0) seen = 1'b1;
      end
      checkOutput({tag, ":grant"}, 32'(sAck), 32'(1) << ch);
      checkOutput({tag, ":latency"}, 32'(lat), 32'd2);
      chReq[ch] = 1'b0;
      @(posedge clk); #1;
      checkOutput({tag, ":release"}, 32'(sAck), 32'h0);
      if (reraise) chReq[ch] = 1'b1;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      nAsserts = 0;
      nFails   = 0;
      sel      = 0;
      chReq    = '0;
      chWe     = '0;
      chAddr   = '0;
      chDin    = '0;

      // Reset state and basic write/read-back on channel 4.
      applyReset();
      checkOutput("rst:ack", 32'(sAck), 32'h0);
      checkOutput("rst:err", 32'(sErr), 32'h0);
      checkOutput("rst:rd", 32'(sRd), 32'h0);
      checkOutput("rst:wp", 32'(sWp), 32'h0);
      checkOutput("rst:wa", 32'(sWa), 32'h0);
      checkOutput("rst:wd", 32'(sWd), 32'h0);
      applyStimulus("wr10", 4, 1'b1, 7'h10, 16'h0010, 1'b0, 16'h0000);
      applyStimulus("rd10", 4, 1'b0, 7'h10, 16'h0000, 1'b0, 16'h0010);
      applyStimulus("rd11", 4, 1'b0, 7'h11, 16'h0000, 1'b0, 16'h0000);
      applyStimulus("wr7F", 0, 1'b1, 7'h7F, 16'hA5A5, 1'b0, 16'h0000);
      applyStimulus("rd7F", 5, 1'b0, 7'h7F, 16'h0000, 1'b0, 16'hA5A5);

      // Simultaneous ch4/ch5 under round-robin, from ptr=0 and then ptr=5.
      applyReset();
      chReq[4] = 1'b1; chReq[5] = 1'b1;
      serveNext("rrP0first", 4, 1'b0);
      serveNext("rrP0second", 5, 1'b0);
      applyStimulus("rrSetPtr", 4, 1'b0, 7'h00, 16'h0000, 1'b0, 16'h0000);
      chReq[4] = 1'b1; chReq[5] = 1'b1;
      serveNext("rrP5first", 5, 1'b0);
      serveNext("rrP5second", 4, 1'b0);

      // Same sequence on the fixed-priority instance: ch4 always first.
      sel = 1;
      applyReset();
      chReq[4] = 1'b1; chReq[5] = 1'b1;
      serveNext("fxAfirst", 4, 1'b0);
      serveNext("fxAsecond", 5, 1'b0);
      applyStimulus("fxSetPtr", 4, 1'b0, 7'h00, 16'h0000, 1'b0, 16'h0000);
      chReq[4] = 1'b1; chReq[5] = 1'b1;
      serveNext("fxBfirst", 4, 1'b0);
      serveNext("fxBsecond", 5, 1'b0);

      // All six channels requesting continuously: rotation 0..5 then back to 0.
      sel = 0;
      applyReset();
      chReq = '1;
      for (int c = 0; c < NCH; c++) begin
         serveNext($sformatf("rot%0d", c), c, 1'b1);
      end
      serveNext("rotWrap", 0, 1'b0);

      // Out-of-range access on the 100-deep instance.
      sel = 2;
      applyReset();
      applyStimulus("oorWr", 2, 1'b1, 7'h7F, 16'hBEEF, 1'b1, 16'h0000);
      applyStimulus("oorRd", 2, 1'b0, 7'h7F, 16'h0000, 1'b1, 16'h0000);
      applyStimulus("oorChk00", 2, 1'b0, 7'h00, 16'h0000, 1'b0, 16'h0000);
      applyStimulus("oorChk1B", 2, 1'b0, 7'h1B, 16'h0000, 1'b0, 16'h0000);
      applyStimulus("oorChk3F", 2, 1'b0, 7'h3F, 16'h0000, 1'b0, 16'h0000);
      applyStimulus("oorChk63", 2, 1'b0, 7'h63, 16'h0000, 1'b0, 16'h0000);
      applyStimulus("lastWr", 2, 1'b1, 7'h63, 16'h1357, 1'b0, 16'h0000);
      applyStimulus("lastRd", 2, 1'b0, 7'h63, 16'h0000, 1'b0, 16'h1357);
      applyStimulus("firstOor", 2, 1'b0, 7'h64, 16'h0000, 1'b1, 16'h0000);

      // Reset colliding with an ACCESS-edge write commit.
      sel = 0;
      applyReset();
      chWe[1] = 1'b1; chAddr[1*AW +: AW] = 7'h05; chDin[1*DW +: DW] = 16'h1234; chReq[1] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rstCommit:wp", 32'(sWp), 32'h0);
      checkOutput("rstCommit:ack", 32'(sAck), 32'h0);
      chReq[1] = 1'b0;
      rst = 1'b0;
      applyStimulus("rstCommit:rd05", 1, 1'b0, 7'h05, 16'h0000, 1'b0, 16'h0000);

      // Reset while ch3 sits in ACK, then its still-held request is served again.
      applyReset();
      applyStimulus("wr02", 1, 1'b1, 7'h02, 16'h0055, 1'b0, 16'h0000);
      chWe[3] = 1'b0; chAddr[3*AW +: AW] = 7'h02; chReq[3] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("ackRst:ack", 32'(sAck), 32'h8);
      checkOutput("ackRst:rd", 32'(sRd), 32'h0055);
      @(posedge clk); #1;
      checkOutput("ackRst:hold", 32'(sAck), 32'h8);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("ackRst:ack0", 32'(sAck), 32'h0);
      checkOutput("ackRst:err0", 32'(sErr), 32'h0);
      checkOutput("ackRst:rd0", 32'(sRd), 32'h0);
      checkOutput("ackRst:wp0", 32'(sWp), 32'h0);
      checkOutput("ackRst:wa0", 32'(sWa), 32'h0);
      checkOutput("ackRst:wd0", 32'(sWd), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("reServe:early", 32'(sAck), 32'h0);
      @(posedge clk); #1;
      checkOutput("reServe:ack", 32'(sAck), 32'h8);
      checkOutput("reServe:rd02", 32'(sRd), 32'h0000);
      chReq[3] = 1'b0;
      @(posedge clk); #1;
      checkOutput("reServe:drop", 32'(sAck), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
